// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with self-generated control.
// Optional output halving with round-half-up when SDF_R2_SCALE_EN is defined.
module sdf_r2_stage #(
    parameter int BF_I = 12,
    parameter int BF_O = BF_I + 1,
    parameter int DLY  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic                   in_sof,
    input  logic signed [BF_I-1:0] in_re,
    input  logic signed [BF_I-1:0] in_im,
    output logic                   out_valid,
    output logic                   out_sof,
    output logic signed [BF_O-1:0] out_re,
    output logic signed [BF_O-1:0] out_im
);
    localparam int CW = $clog2(2 * DLY);
    localparam int DW = BF_I + 1;
    localparam logic [CW-1:0] DLY_C  = CW'(DLY);
    localparam logic [CW-1:0] LAST_C = CW'(2 * DLY - 1);

    typedef logic signed [DW-1:0] dw_t;
    typedef logic signed [DW:0]   xw_t;

    function automatic dw_t sext(input logic signed [BF_I-1:0] x);
        return {x[BF_I-1], x};
    endfunction

    function automatic xw_t round_half(input dw_t v);
        xw_t w;
        w = {v[DW-1], v};
        w = w + xw_t'(1);
        return w >>> 1;
    endfunction

    function automatic logic signed [BF_O-1:0] out_map(input dw_t v);
`ifdef SDF_R2_SCALE_EN
        return BF_O'(round_half(v));
`else
        return BF_O'({v[DW-1], v});
`endif
    endfunction

    logic                   vld_q, sof_q;
    logic signed [BF_I-1:0] re_q, im_q;
    logic [CW-1:0]          cnt_q, cnt_d, cnt_eff;
    logic                   pend_q, pend_d, pend_eff;
    dw_t                    dl_re_q [DLY];
    dw_t                    dl_im_q [DLY];
    dw_t                    head_re, head_im, b_re, b_im, wr_re, wr_im;
    logic                   phase_b;
    logic                   ovld_q, ovld_d, osof_q, osof_d;
    logic signed [BF_O-1:0] ore_q, ore_d, oim_q, oim_d;

    // Input register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            sof_q <= 1'b0;
            re_q  <= '0;
            im_q  <= '0;
        end else begin
            vld_q <= in_valid;
            sof_q <= in_sof;
            re_q  <= in_re;
            im_q  <= in_im;
        end
    end

    // Butterfly control and arithmetic on the registered sample
    always_comb begin
        cnt_eff  = sof_q ? '0 : cnt_q;
        pend_eff = pend_q & ~(sof_q & (cnt_q != '0));
        head_re  = dl_re_q[0];
        head_im  = dl_im_q[0];
        b_re     = sext(re_q);
        b_im     = sext(im_q);
        phase_b  = (cnt_eff >= DLY_C);
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        wr_re    = b_re;
        wr_im    = b_im;
        ovld_d   = 1'b0;
        osof_d   = 1'b0;
        ore_d    = ore_q;
        oim_d    = oim_q;
        if (vld_q) begin
            cnt_d  = cnt_eff + CW'(1);
            pend_d = pend_eff | (cnt_eff == LAST_C);
            if (phase_b) begin
                wr_re  = head_re - b_re;
                wr_im  = head_im - b_im;
                ovld_d = 1'b1;
                osof_d = (cnt_eff == DLY_C);
                ore_d  = out_map(head_re + b_re);
                oim_d  = out_map(head_im + b_im);
            end else begin
                ovld_d = pend_eff;
                ore_d  = out_map(head_re);
                oim_d  = out_map(head_im);
            end
        end
    end

    // Control state and output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ovld_q <= 1'b0;
            osof_q <= 1'b0;
            ore_q  <= '0;
            oim_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovld_q <= ovld_d;
            osof_q <= osof_d;
            ore_q  <= ore_d;
            oim_q  <= oim_d;
        end
    end

    // Delay line is left unreset: pend masks whatever it holds after reset
    always_ff @(posedge clk) begin
        if (vld_q) begin
            for (int i = 0; i < DLY - 1; i++) begin
                dl_re_q[i] <= dl_re_q[i+1];
                dl_im_q[i] <= dl_im_q[i+1];
            end
            dl_re_q[DLY-1] <= wr_re;
            dl_im_q[DLY-1] <= wr_im;
        end
    end

    assign out_valid = ovld_q;
    assign out_sof   = osof_q;
    assign out_re    = ore_q;
    assign out_im    = oim_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Testbench for sdf_r2_stage: directed frames plus random traffic against a FIFO-level model.
module tb_sdf_r2_stage;
    localparam int BF_I = 12;
    localparam int BF_O = BF_I + 1;
    localparam int DLY  = 4;
    localparam int FL   = 2 * DLY;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic                   in_sof = 1'b0;
    logic signed [BF_I-1:0] in_re = '0;
    logic signed [BF_I-1:0] in_im = '0;
    logic                   out_valid, out_sof;
    logic signed [BF_O-1:0] out_re, out_im;

    sdf_r2_stage #(.BF_I(BF_I), .BF_O(BF_O), .DLY(DLY)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_sof(out_sof),
        .out_re(out_re), .out_im(out_im)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit s; int re; int im; } exp_t;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_cnt;
    bit   m_pend;
    int   m_qre[$];
    int   m_qim[$];
    exp_t e1, e2;

    task automatic chk(input string tag, input integer obs, input integer exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int scl(input int v);
`ifdef SDF_R2_SCALE_EN
        return (v + 1) >>> 1;
`else
        return v;
`endif
    endfunction

    function automatic void model_reset();
        m_cnt  = 0;
        m_pend = 0;
        m_qre.delete();
        m_qim.delete();
        for (int i = 0; i < DLY; i++) begin
            m_qre.push_back(0);
            m_qim.push_back(0);
        end
        e1 = '{0, 0, 0, 0};
        e2 = '{0, 0, 0, 0};
    endfunction

    // Frame-level behaviour: first half stores, second half emits sum and stores difference
    function automatic exp_t model_step(input bit acc, input bit sof, input int re, input int im);
        exp_t e;
        int hr, hi;
        e = '{0, 0, 0, 0};
        if (!acc) return e;
        if (sof) begin
            if (m_cnt != 0) m_pend = 0;
            m_cnt = 0;
        end
        hr = m_qre.pop_front();
        hi = m_qim.pop_front();
        if (m_cnt < DLY) begin
            m_qre.push_back(re);
            m_qim.push_back(im);
            e.v  = m_pend;
            e.re = scl(hr);
            e.im = scl(hi);
        end else begin
            m_qre.push_back(hr - re);
            m_qim.push_back(hi - im);
            e.v  = 1;
            e.s  = (m_cnt == DLY);
            e.re = scl(hr + re);
            e.im = scl(hi + im);
        end
        if (m_cnt == FL - 1) m_pend = 1;
        m_cnt = (m_cnt + 1) % FL;
        return e;
    endfunction

    task automatic step(input bit v, input bit s, input int re, input int im);
        exp_t en;
        @(negedge clk);
        chk("out_valid", out_valid, e2.v);
        chk("out_sof", out_sof, e2.v ? e2.s : 1'b0);
        if (e2.v) begin
            chk("out_re", out_re, e2.re);
            chk("out_im", out_im, e2.im);
        end
        in_valid = v;
        in_sof   = s;
        in_re    = re[BF_I-1:0];
        in_im    = im[BF_I-1:0];
        en = model_step(v, s, re, im);
        e2 = e1;
        e1 = en;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_sof", out_sof, 0);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        rst_n = 1'b1;

        // Ramp frame then zero frame, back to back
        for (int i = 0; i < FL; i++) step(1, i == 0, i + 1, 0);
        for (int i = 0; i < FL; i++) step(1, i == 0, 0, 0);
        idle(3);

        // Same frames with alternating gaps
        for (int i = 0; i < FL; i++) begin step(1, i == 0, i + 1, 0); step(0, 0, 0, 0); end
        for (int i = 0; i < FL; i++) begin step(1, i == 0, 0, 0); step(0, 0, 0, 0); end
        idle(3);

        // Abort: frame 2 restarted at cnt=5
        for (int i = 0; i < FL; i++) step(1, i == 0, i + 1, -i);
        for (int i = 0; i < 5; i++) step(1, i == 0, 10 * i, 3);
        for (int i = 0; i < FL; i++) step(1, i == 0, 7 - 3 * i, 2 * i);
        for (int i = 0; i < FL; i++) step(1, i == 0, 0, 0);
        idle(3);

        // Extremes and rounding
        for (int i = 0; i < FL; i++) step(1, i == 0, -2048, -2048);
        for (int i = 0; i < FL; i++) step(1, i == 0, 0, 2047);
        for (int i = 0; i < FL; i++) step(1, i == 0, (i < DLY) ? 1 : 2, (i < DLY) ? -1 : -2);
        for (int i = 0; i < FL; i++) step(1, i == 0, 0, 0);
        idle(3);

        // Random frames with gaps and occasional aborts
        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < FL; i++) begin
                while ($urandom_range(3) == 0) step(0, 0, 0, 0);
                step(1, (i == 0) || ($urandom_range(31) == 0), rnd_s(), rnd_s());
            end
        end
        idle(3);

        // Asynchronous reset mid-frame
        for (int i = 0; i < FL; i++) step(1, i == 0, 100 + i, i);
        for (int i = 0; i < 5; i++) step(1, i == 0, i + 1, 0);
        #2;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_sof", out_sof, 0);
        chk("async_rst_re", out_re, 0);
        chk("async_rst_im", out_im, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < FL; i++) step(1, 1'b0, i + 1, 0);
        for (int i = 0; i < FL; i++) step(1, i == 0, 0, 0);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
